// File: rtl/seq_matrix_mult_core.sv
// Sequential MxM matrix multiplier, one MAC per clock, row-major result handshake.
// Optional macro SEQ_MM_SATURATE_EN: wide accumulator with clamped results.
module seq_matrix_mult_core #(
    parameter int M  = 4,
    parameter int DW = 32,
    parameter int IW = ($clog2(M) < 1) ? 1 : $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic          z_ack,
    output logic [IW-1:0] a_i,
    output logic [IW-1:0] a_j,
    output logic [IW-1:0] b_i,
    output logic [IW-1:0] b_j,
    output logic [DW-1:0] z_out,
    output logic [IW-1:0] z_i,
    output logic [IW-1:0] z_j,
    output logic          z_stb,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT,
        FIN
    } state_t;

    localparam logic [IW-1:0] KMAX = IW'(M - 1);

    state_t        state, state_nx;
    logic [IW-1:0] i, j, k;
    logic [DW-1:0] res;
    logic          last_k, last_el;

`ifdef SEQ_MM_SATURATE_EN
    localparam int AW = 2 * DW + IW;
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0]   acc, sum;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        prod = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
        sum  = acc + $signed({{IW{prod[2*DW-1]}}, prod});
        res  = sum[DW-1:0];
        if (sum > SMAX)
            res = SMAX[DW-1:0];
        else if (sum < SMIN)
            res = SMIN[DW-1:0];
    end
`else
    logic [DW-1:0] acc, sum;

    // Low DW bits of a product are the same for signed and unsigned operands.
    always_comb begin
        sum = acc + a_in * b_in;
        res = sum;
    end
`endif

    assign last_k  = (k == KMAX);
    assign last_el = (i == KMAX) && (j == KMAX);

    assign a_i = i;
    assign a_j = k;
    assign b_i = k;
    assign b_j = j;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = MAC;
            MAC:  if (last_k) state_nx = OUT;
            OUT:  if (z_ack) state_nx = last_el ? FIN : MAC;
            FIN:  if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            z_out <= '0;
            z_i   <= '0;
            z_j   <= '0;
            z_stb <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    if (last_k) begin
                        z_out <= res;
                        z_i   <= i;
                        z_j   <= j;
                        z_stb <= 1'b1;
                    end else begin
                        acc <= sum;
                        k   <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (z_ack) begin
                        z_stb <= 1'b0;
                        if (last_el) begin
                            done <= 1'b1;
                        end else begin
                            if (j == KMAX) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                            k   <= '0;
                            acc <= '0;
                        end
                    end
                end
                FIN: begin
                    if (!start) done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_matrix_mult_core.sv
// Scoreboard bench for seq_matrix_mult_core against a plain-arithmetic
// matrix product model; follows SEQ_MM_SATURATE_EN if defined.
module tb_seq_matrix_mult_core;

    localparam int M  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct {
        int          r;
        int          c;
        logic [31:0] v;
    } exp_t;

    logic          clk = 0;
    logic          rst = 0;
    logic          start = 0;
    logic          z_ack = 0;
    logic [DW-1:0] a_in, b_in;
    logic [IW-1:0] a_i, a_j, b_i, b_j, z_i, z_j;
    logic [DW-1:0] z_out;
    logic          z_stb, done;

    logic [31:0] A [M][M];
    logic [31:0] B [M][M];

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   strobes = 0;
    int   ack_en = 0;
    int   ack_delay = 0;
    int   manual_cnt = 0;

    seq_matrix_mult_core #(.M(M), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .z_ack(z_ack),
        .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j),
        .z_out(z_out), .z_i(z_i), .z_j(z_j),
        .z_stb(z_stb), .done(done)
    );

    assign a_in = A[a_i][a_j];
    assign b_in = B[b_i][b_j];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_elem(input int r, input int c);
        logic signed [127:0] s;
        longint p;
        s = 0;
        for (int t = 0; t < M; t++) begin
            p = longint'($signed(A[r][t])) * longint'($signed(B[t][c]));
            s = s + p;
        end
`ifdef SEQ_MM_SATURATE_EN
        if (s > 128'sd2147483647) return 32'h7FFFFFFF;
        if (s < -128'sd2147483648) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                e.r = r;
                e.c = c;
                e.v = ref_elem(r, c);
                q.push_back(e);
            end
    endtask

    // Monitor: each new strobe is one result element.
    initial begin
        logic stb_prev;
        exp_t e;
        stb_prev = 0;
        forever begin
            @(negedge clk);
            if (rst && z_stb && !stb_prev) begin
                strobes++;
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 64'(strobes), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("z_i", 64'(z_i), 64'(e.r));
                    chk("z_j", 64'(z_j), 64'(e.c));
                    chk("z_out", 64'(z_out), 64'(e.v));
                end
            end
            stb_prev = z_stb;
        end
    end

    // Sole driver of z_ack: automatic acks after a delay, or manual pulses.
    initial begin
        int used, wcnt;
        used = 0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (z_ack) begin
                z_ack = 0;
            end else if (manual_cnt != used) begin
                z_ack = 1;
                used++;
            end else if (ack_en != 0 && z_stb) begin
                if (wcnt >= ack_delay) begin
                    z_ack = 1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_outs"}, {z_out, 4'(z_i), 4'(z_j), 4'(a_i), 4'(a_j), 4'(b_i), 4'(b_j),
            2'b0, z_stb, done}, 64'd0);
    endtask

    task automatic run(input int delay, input logic chk_lat);
        int n;
        ack_delay = delay;
        ack_en = 1;
        strobes = 0;
        push_expected();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        if (chk_lat) begin
            n = 0;
            do begin
                @(posedge clk);
                n++;
                #1;
            end while (!z_stb && n < 50);
            chk("first_latency", 64'(n), 64'(M));
        end
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("strobe_count", 64'(strobes), 64'(M * M));
        chk("queue_empty", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_held_no_restart", {62'd0, done, z_stb}, 64'd2);
        start = 0;
        @(posedge clk);
        #1;
        chk("done_clear", 64'(done), 64'd0);
        q.delete();
        ack_en = 0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                A[r][c] = $urandom;
                B[r][c] = $urandom;
            end
    endtask

    initial begin
        int n;
        logic [31:0] h_out;
        logic [IW-1:0] h_i, h_j;

        fill_random();
        #1;
        chk_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk_zero_outputs("post_reset_idle");

        // identity x ramp
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                A[r][c] = (r == c) ? 32'd1 : 32'd0;
                B[r][c] = 32'(4 * r + c);
            end
        run(0, 1'b1);

        // constants
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                A[r][c] = 32'd2;
                B[r][c] = 32'd3;
            end
        run(1, 1'b1);

        // overflow on element (0,0)
        fill_random();
        for (int t = 0; t < M; t++) begin
            A[0][t] = 32'h00010000;
            B[t][0] = 32'h00010000;
        end
        run(2, 1'b0);

        // signed
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                A[r][c] = 32'hFFFFFFFF;
                B[r][c] = 32'd5;
            end
        run(0, 1'b0);

        for (int t = 0; t < 3; t++) begin
            fill_random();
            run($urandom_range(0, 3), 1'b0);
        end

        // backpressure on the first element, plus a stray ack
        fill_random();
        strobes = 0;
        push_expected();
        @(negedge clk);
        start = 1;
        n = 0;
        while (!z_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_stb_up", 64'(z_stb), 64'd1);
        h_out = z_out;
        h_i = z_i;
        h_j = z_j;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("bp_hold", {z_out, 4'(z_i), 4'(z_j), 23'd0, z_stb},
                {h_out, 4'(h_i), 4'(h_j), 23'd0, 1'b1});
        end
        manual_cnt++;
        repeat (2) @(negedge clk);
        chk("bp_stb_fell", 64'(z_stb), 64'd0);
        manual_cnt++;
        repeat (2) @(negedge clk);
        chk("bp_stray_ack", {62'd0, z_stb, done}, 64'd0);
        ack_delay = 0;
        ack_en = 1;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_strobes", 64'(strobes), 64'(M * M));
        start = 0;
        @(negedge clk);
        q.delete();
        ack_en = 0;

        // reset in the middle of element (1,2)
        fill_random();
        push_expected();
        ack_delay = 0;
        ack_en = 1;
        @(negedge clk);
        start = 1;
        n = 0;
        while (!(a_i == 1 && b_j == 2 && a_j == 1 && !z_stb) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_elem_1_2", 64'(n < 2000), 64'd1);
        rst = 0;
        #1;
        chk_zero_outputs("async_reset");
        q.delete();
        ack_en = 0;
        start = 0;
        @(negedge clk);
        rst = 1;
        repeat (10) @(negedge clk);
        chk_zero_outputs("idle_after_reset");
        fill_random();
        run(1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
